nim_game_ctrl: RTL and testbench
================================

# nim_game_ctrl

Game-of-Nim move controller. It consumes the single-cycle, debounced button pulses produced by the push-button conditioning stage and holds the pile counts. It sequences alternating turns of two players: select a pile, choose how many stones to take, confirm. It detects the end of the game, where the player who takes the last stone wins, and drives registered state for the display stage downstream.

## Interface
Parameters:
- NUM_PILES, 3: number of piles, 2..8.
- PILE_W, 3: bits per pile count.
- INIT_PILES, {3'd7,3'd5,3'd3}: packed initial counts, NUM_PILES*PILE_W bits; pile i occupies bits [i*PILE_W +: PILE_W].

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start_p  in  1  start/restart pulse, one cycle
- next_p  in  1  in SELECT, advance pile selection; in TAKE, cancel the move
- take_p  in  1  in SELECT, begin a move; in TAKE, add one stone to the move
- confirm_p  in  1  commit the pending move
- piles  out  NUM_PILES*PILE_W  current pile counts
- sel_pile  out  $clog2(NUM_PILES)  selected pile index
- pending  out  PILE_W  stones in the move being built
- player  out  1  player to move, 0 or 1
- in_move  out  1  high in TAKE
- game_over  out  1  high in OVER
- winner  out  1  valid while game_over
- move_done  out  1  one-cycle pulse per committed move

## Operation
- States are IDLE, SELECT, TAKE, CHECK and OVER.
- Reset values:
  - state=IDLE; piles=INIT_PILES.
  - sel_pile=0, pending=0, player=0.
  - winner=0, move_done=0.
  - in_move=0, game_over=0.
- IDLE:
  - start_p sets player=0 and sel_pile=first non-empty pile from index 0, then goes to SELECT.
  - If every pile is zero, start_p instead goes to OVER with winner=1.
  - Other pulses are ignored.
- SELECT:
  - next_p moves sel_pile to the next non-empty pile after the current one, wrapping modulo NUM_PILES. If no other pile is non-empty, sel_pile is unchanged.
  - take_p sets pending=1 and goes to TAKE. The selected pile is never empty in SELECT.
- TAKE:
  - take_p increments pending, saturating at piles[sel_pile].
  - next_p clears pending to 0 and returns to SELECT; the pile is unchanged.
  - confirm_p does piles[sel_pile] -= pending, clears pending to 0, pulses move_done and goes to CHECK.
- CHECK lasts exactly one cycle and ignores all pulses:
  - If all piles are 0: winner=player, go to OVER.
  - Otherwise: toggle player, set sel_pile=first non-empty pile from index 0, go to SELECT.
- OVER:
  - start_p reloads INIT_PILES, sets player=0, clears winner, sets sel_pile=first non-empty pile, and goes to SELECT.
  - The all-zero case is handled as in IDLE.
- start_p is ignored in SELECT, TAKE and CHECK.
- Simultaneous pulses resolve with priority confirm_p > take_p > next_p. Only the winning pulse acts in that cycle; the others are dropped.
- Arithmetic:
  - pending is never 0 in TAKE and never exceeds piles[sel_pile], so the subtraction cannot underflow.
  - No wrap-around on any count.
- Reset mid-game returns every register to its reset value on the next clock edge.

## Timing
- All outputs are registered.
- A pulse sampled at edge N updates its outputs after edge N.
- move_done is high for exactly the cycle following the confirm_p edge, coincident with the state being CHECK.
- Turn hand-over and the game_over result are visible two edges after confirm_p, with CHECK in between.
- Pulses arrive at least one cycle apart in normal use. Back-to-back pulses on consecutive cycles must each be honoured, except pulses arriving during CHECK, which are ignored.

## Structure
- nim_pkg holds:
  - the state enum typedef: IDLE, SELECT, TAKE, CHECK, OVER;
  - default constants for NUM_PILES and PILE_W.
- Sub-module nim_next_pile:
  - combinational finder for the next non-empty pile;
  - inputs: piles vector, start index, and a mode bit choosing "after start, wrapping" or "from 0";
  - outputs: found index and an any_nonempty flag.
  - It is instantiated once and reused for SELECT advancing, CHECK and start.
- The all-zero test in CHECK uses any_nonempty.

## Test plan
- Reset, then start_p: piles=7/5/3 (pile2/1/0), sel_pile=0, player=0, state SELECT.
- take_p three times, then confirm_p on pile0=3: pending 1,2,3, then pile0=0, move_done for one cycle, then player=1, sel_pile=1.
- From sel_pile=1 with pile0=0, press next_p twice: sel_pile goes 2 then 1, skipping empty pile0.
- In TAKE with pending=2, assert take_p and confirm_p in the same cycle: confirm wins, pile decremented by 2.
- In TAKE, press take_p ten times on pile1=5: pending saturates at 5. Then next_p: pending=0, pile1 still 5, state SELECT.
- Play to the last stone, taken by player 1: game_over=1, winner=1. Then start_p: piles reload 7/5/3, player=0. Assert reset mid-TAKE: all outputs return to their reset values.

Source files
------------

// File: rtl/nim_pkg.sv
// Shared types and default sizing for the Nim move controller.
package nim_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    TAKE,
    CHECK,
    OVER
  } state_e;

  localparam int NUM_PILES_DEF = 3;
  localparam int PILE_W_DEF    = 3;

endpackage

// File: rtl/nim_next_pile.sv
// Combinational search for a non-empty pile, either from index 0 or after start_i
// with wrap-around; falls back to start_i when nothing qualifies.
module nim_next_pile
  import nim_pkg::*;
#(
  parameter int NUM_PILES = NUM_PILES_DEF,
  parameter int PILE_W    = PILE_W_DEF,
  parameter int IDX_W     = $clog2(NUM_PILES)
) (
  input  logic [NUM_PILES*PILE_W-1:0] piles_i,
  input  logic [IDX_W-1:0]            start_i,
  input  logic                        from_zero_i,
  output logic [IDX_W-1:0]            idx_o,
  output logic                        any_o
);

  int   c;
  logic found;

  always_comb begin
    idx_o = start_i;
    any_o = 1'b0;
    found = 1'b0;
    c     = 0;
    for (int k = 0; k < NUM_PILES; k++) begin
      any_o = any_o | (piles_i[k*PILE_W +: PILE_W] != '0);
    end
    // k == NUM_PILES in wrap mode lands back on start_i itself
    for (int k = 1; k <= NUM_PILES; k++) begin
      c = from_zero_i ? (k - 1) : (int'(start_i) + k);
      if (c >= NUM_PILES) c = c - NUM_PILES;
      if (!found && (piles_i[c*PILE_W +: PILE_W] != '0)) begin
        idx_o = IDX_W'(c);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nim_game_ctrl.sv
// Nim turn sequencer: select pile, build a move, confirm, detect last-stone win.
// All outputs registered; pulses in CHECK are dropped, priority confirm > take > next.
module nim_game_ctrl
  import nim_pkg::*;
#(
  parameter int NUM_PILES = NUM_PILES_DEF,
  parameter int PILE_W    = PILE_W_DEF,
  parameter logic [NUM_PILES*PILE_W-1:0] INIT_PILES = {3'd7, 3'd5, 3'd3}
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start_p,
  input  logic                          next_p,
  input  logic                          take_p,
  input  logic                          confirm_p,
  output logic [NUM_PILES*PILE_W-1:0]   piles,
  output logic [$clog2(NUM_PILES)-1:0]  sel_pile,
  output logic [PILE_W-1:0]             pending,
  output logic                          player,
  output logic                          in_move,
  output logic                          game_over,
  output logic                          winner,
  output logic                          move_done
);

  localparam int IDX_W = $clog2(NUM_PILES);

  state_e                        state_q, state_d;
  logic [NUM_PILES*PILE_W-1:0]   piles_q, piles_d;
  logic [IDX_W-1:0]              sel_q, sel_d;
  logic [PILE_W-1:0]             pend_q, pend_d;
  logic                          player_q, player_d;
  logic                          winner_q, winner_d;
  logic                          done_q, done_d;

  logic [NUM_PILES*PILE_W-1:0]   find_piles;
  logic [IDX_W-1:0]              find_idx;
  logic                          find_any;
  logic [PILE_W-1:0]             cur_pile;

  // Outside a game the search runs on the counts that a start will load
  assign find_piles = (state_q == IDLE || state_q == OVER) ? INIT_PILES : piles_q;
  assign cur_pile   = piles_q[sel_q*PILE_W +: PILE_W];

  nim_next_pile #(
    .NUM_PILES (NUM_PILES),
    .PILE_W    (PILE_W),
    .IDX_W     (IDX_W)
  ) u_next_pile (
    .piles_i     (find_piles),
    .start_i     (sel_q),
    .from_zero_i (state_q != SELECT),
    .idx_o       (find_idx),
    .any_o       (find_any)
  );

  always_comb begin
    state_d  = state_q;
    piles_d  = piles_q;
    sel_d    = sel_q;
    pend_d   = pend_q;
    player_d = player_q;
    winner_d = winner_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE, OVER: begin
        if (start_p) begin
          piles_d  = INIT_PILES;
          player_d = 1'b0;
          if (!find_any) begin
            winner_d = 1'b1;
            state_d  = OVER;
          end else begin
            winner_d = 1'b0;
            sel_d    = find_idx;
            state_d  = SELECT;
          end
        end
      end
      SELECT: begin
        if (confirm_p) begin
          state_d = SELECT;
        end else if (take_p) begin
          pend_d  = PILE_W'(1);
          state_d = TAKE;
        end else if (next_p) begin
          sel_d = find_idx;
        end
      end
      TAKE: begin
        if (confirm_p) begin
          piles_d[sel_q*PILE_W +: PILE_W] = cur_pile - pend_q;
          pend_d  = '0;
          done_d  = 1'b1;
          state_d = CHECK;
        end else if (take_p) begin
          if (pend_q < cur_pile) pend_d = pend_q + PILE_W'(1);
        end else if (next_p) begin
          pend_d  = '0;
          state_d = SELECT;
        end
      end
      CHECK: begin
        if (!find_any) begin
          winner_d = player_q;
          state_d  = OVER;
        end else begin
          player_d = ~player_q;
          sel_d    = find_idx;
          state_d  = SELECT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      piles_q  <= INIT_PILES;
      sel_q    <= '0;
      pend_q   <= '0;
      player_q <= 1'b0;
      winner_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      piles_q  <= piles_d;
      sel_q    <= sel_d;
      pend_q   <= pend_d;
      player_q <= player_d;
      winner_q <= winner_d;
      done_q   <= done_d;
    end
  end

  assign piles     = piles_q;
  assign sel_pile  = sel_q;
  assign pending   = pend_q;
  assign player    = player_q;
  assign in_move   = (state_q == TAKE);
  assign game_over = (state_q == OVER);
  assign winner    = winner_q;
  assign move_done = done_q;

endmodule

// File: tb/tb_nim_game_ctrl.sv
// Directed test-plan walk plus randomized pulses, checked every cycle against a game-level model.
module tb_nim_game_ctrl;

  localparam int N = 3;
  localparam int W = 3;

  logic clk = 1'b0;
  logic reset, start_p, next_p, take_p, confirm_p;
  logic [N*W-1:0] piles;
  logic [1:0]     sel_pile;
  logic [W-1:0]   pending;
  logic player, in_move, game_over, winner, move_done;

  nim_game_ctrl dut (
    .clk(clk), .reset(reset), .start_p(start_p), .next_p(next_p),
    .take_p(take_p), .confirm_p(confirm_p), .piles(piles), .sel_pile(sel_pile),
    .pending(pending), .player(player), .in_move(in_move), .game_over(game_over),
    .winner(winner), .move_done(move_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {PH_IDLE, PH_SELECT, PH_TAKE, PH_CHECK, PH_OVER} phase_t;
  int     init_cnt [N] = '{3, 5, 7};
  int     mp [N];
  int     msel, mpend, mpl, mwin, mdone;
  phase_t mph;
  bit     mvalid = 0;

  function automatic int total();
    int s = 0;
    for (int i = 0; i < N; i++) s += mp[i];
    return s;
  endfunction

  function automatic int first_ne();
    for (int i = 0; i < N; i++) if (mp[i] != 0) return i;
    return 0;
  endfunction

  function automatic int next_after(input int from);
    for (int k = 1; k <= N; k++) if (mp[(from + k) % N] != 0) return (from + k) % N;
    return from;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mph = PH_IDLE; mp = init_cnt; msel = 0; mpend = 0; mpl = 0; mwin = 0; mdone = 0;
      mvalid = 1;
    end else if (mvalid) begin
      mdone = 0;
      case (mph)
        PH_IDLE, PH_OVER: if (start_p) begin
          mp = init_cnt; mpl = 0;
          if (total() == 0) begin mwin = 1; mph = PH_OVER; end
          else begin mwin = 0; msel = first_ne(); mph = PH_SELECT; end
        end
        PH_SELECT: if (!confirm_p) begin
          if (take_p) begin mpend = 1; mph = PH_TAKE; end
          else if (next_p) msel = next_after(msel);
        end
        PH_TAKE: begin
          if (confirm_p) begin
            mp[msel] -= mpend; mpend = 0; mdone = 1; mph = PH_CHECK;
          end else if (take_p) begin
            if (mpend < mp[msel]) mpend++;
          end else if (next_p) begin
            mpend = 0; mph = PH_SELECT;
          end
        end
        PH_CHECK: begin
          if (total() == 0) begin mwin = mpl; mph = PH_OVER; end
          else begin mpl = 1 - mpl; msel = first_ne(); mph = PH_SELECT; end
        end
        default: ;
      endcase
    end
  end

  function automatic int pack_model();
    int v = 0;
    for (int i = 0; i < N; i++) v |= (mp[i] << (i * W));
    return v;
  endfunction

  always @(negedge clk) begin
    if (mvalid) begin
      chk("piles", int'(piles), pack_model());
      chk("sel_pile", int'(sel_pile), msel);
      chk("pending", int'(pending), mpend);
      chk("player", int'(player), mpl);
      chk("in_move", int'(in_move), int'(mph == PH_TAKE));
      chk("game_over", int'(game_over), int'(mph == PH_OVER));
      chk("winner", int'(winner), mwin);
      chk("move_done", int'(move_done), mdone);
    end
  end

  // ---------------- stimulus ----------------
  task automatic apply(input bit s, input bit n, input bit t, input bit c);
    start_p = s; next_p = n; take_p = t; confirm_p = c;
    @(posedge clk); #1;
    start_p = 0; next_p = 0; take_p = 0; confirm_p = 0;
  endtask

  task automatic idle();
    apply(0, 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1; start_p = 0; next_p = 0; take_p = 0; confirm_p = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    chk("rst_piles", int'(piles), 9'o753);
    chk("rst_sel", int'(sel_pile), 0);
    chk("rst_game_over", int'(game_over), 0);

    apply(1, 0, 0, 0);
    chk("start_piles", int'(piles), 9'o753);
    chk("start_sel", int'(sel_pile), 0);
    idle();
    for (int i = 1; i <= 3; i++) begin
      apply(0, 0, 1, 0);
      chk("take_pending", int'(pending), i);
      idle();
    end
    apply(0, 0, 0, 1);
    chk("confirm_done", int'(move_done), 1);
    chk("confirm_piles", int'(piles), 9'o750);
    idle();
    chk("done_low", int'(move_done), 0);
    chk("handover_player", int'(player), 1);
    chk("handover_sel", int'(sel_pile), 1);

    apply(0, 1, 0, 0);
    chk("next_sel_a", int'(sel_pile), 2);
    idle();
    apply(0, 1, 0, 0);
    chk("next_sel_b", int'(sel_pile), 1);

    for (int i = 0; i < 11; i++) apply(0, 0, 1, 0);
    chk("sat_pending", int'(pending), 5);
    apply(0, 1, 0, 0);
    chk("cancel_pending", int'(pending), 0);
    chk("cancel_in_move", int'(in_move), 0);
    chk("cancel_piles", int'(piles), 9'o750);

    apply(0, 0, 1, 0);
    apply(0, 0, 1, 0);
    apply(0, 0, 1, 1);
    chk("prio_piles", int'(piles), 9'o730);
    idle();
    chk("prio_player", int'(player), 0);

    for (int i = 0; i < 3; i++) apply(0, 0, 1, 0);
    apply(0, 0, 0, 1);
    idle();
    chk("p1_sel", int'(sel_pile), 2);
    for (int i = 0; i < 7; i++) apply(0, 0, 1, 0);
    apply(0, 0, 0, 1);
    idle();
    chk("end_game_over", int'(game_over), 1);
    chk("end_winner", int'(winner), 1);

    apply(1, 0, 0, 0);
    chk("restart_piles", int'(piles), 9'o753);
    chk("restart_player", int'(player), 0);
    chk("restart_winner", int'(winner), 0);

    apply(0, 0, 1, 0);
    apply(0, 0, 1, 0);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("midrst_in_move", int'(in_move), 0);
    chk("midrst_pending", int'(pending), 0);
    chk("midrst_piles", int'(piles), 9'o753);

    for (int cyc = 0; cyc < 4000; cyc++) begin
      bit s, n, t, c;
      s = ($urandom_range(0, 99) < 5);
      n = ($urandom_range(0, 99) < 20);
      t = ($urandom_range(0, 99) < 45);
      c = ($urandom_range(0, 99) < 15);
      if ($urandom_range(0, 999) < 3) begin
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
      end else begin
        apply(s, n, t, c);
      end
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
